// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage: the 3-bit ALU command codes and
// the packed ALU output record that travels through the output FIFO.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] CMD_ADD  = 3'b000;
    localparam logic [2:0] CMD_SUB  = 3'b001;
    localparam logic [2:0] CMD_XOR  = 3'b010;
    localparam logic [2:0] CMD_SLT  = 3'b011;
    localparam logic [2:0] CMD_AND  = 3'b100;
    localparam logic [2:0] CMD_NAND = 3'b101;
    localparam logic [2:0] CMD_NOR  = 3'b110;
    localparam logic [2:0] CMD_OR   = 3'b111;

    typedef struct packed {
        logic [31:0] result;
        logic        carryout;
        logic        zero;
        logic        overflow;
    } alu_out_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// -----------------------------------------------------------------------------
// alu_issue_stage_if
// Operation input channel and result output channel of the ALU issue stage.
//   in_*  : operation from decode/operand fetch (in_valid/in_ready handshake)
//   out_* : FIFO head toward writeback      (out_valid/out_ready handshake)
// Handshake: a transfer happens on a rising edge where valid & ready are both 1.
// A source holding valid=1 keeps its payload stable until that transfer; ready
// never depends combinationally on valid.
// Modports: master = upstream/downstream environment, slave = the stage.
// -----------------------------------------------------------------------------
interface alu_issue_stage_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [2:0]       in_cmd;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_carryout;
    logic             out_zero;
    logic             out_overflow;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_cmd, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_carryout, out_zero,
               out_overflow, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cmd, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_carryout, out_zero,
               out_overflow, out_tag
    );
endinterface

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Combinational 32-bit ALU.
//   a, b : operands
//   cmd  : ADD, SUB, XOR, SLT (signed), AND, NAND, NOR, OR
//   y    : result plus carryout/zero/overflow; flags are 0 except for ADD/SUB
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  cmd,
    output alu_out_t    y
);
    logic        do_sub;
    logic [31:0] b_eff;
    logic [32:0] sum;
    logic        ovf;

    always_comb begin
        // SUB and SLT share the adder in subtract mode (a + ~b + 1)
        do_sub = (cmd != CMD_ADD);
        b_eff  = do_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {32'd0, do_sub};
        ovf    = (a[31] == b_eff[31]) && (sum[31] != a[31]);

        y = '0;
        case (cmd)
            CMD_ADD, CMD_SUB: begin
                y.result   = sum[31:0];
                y.carryout = sum[32];
                y.zero     = (sum[31:0] == 32'd0);
                y.overflow = ovf;
            end
            // signed less-than: sign of the difference corrected by overflow
            CMD_SLT:  y.result = {31'd0, sum[31] ^ ovf};
            CMD_XOR:  y.result = a ^ b;
            CMD_AND:  y.result = a & b;
            CMD_NAND: y.result = ~(a & b);
            CMD_NOR:  y.result = ~(a | b);
            default:  y.result = a | b;
        endcase
    end
endmodule

// File: rtl/alu_out_fifo.sv
// -----------------------------------------------------------------------------
// alu_out_fifo
// Synchronous FIFO of ENTRIES words with async active-high reset.
//   push/wdata : write at tail (ignored when full unless popping same cycle)
//   pop        : remove head (ignored when empty)
//   rdata      : head word; count/full/empty : occupancy
// Pointers wrap modulo ENTRIES, which need not be a power of two.
// -----------------------------------------------------------------------------
module alu_out_fifo #(
    parameter int ENTRIES = 2,
    parameter int W       = 39,
    parameter int CW      = $clog2(ENTRIES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [W-1:0]  mem [ENTRIES];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CW'(ENTRIES));
    assign empty = (count == '0);
    assign rd_en = pop & ~empty;
    // a full FIFO can still take a write when the head leaves the same cycle
    assign wr_en = push & (~full | rd_en);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (rd_en) rd_ptr <= nxt(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Registered issue stage for the 32-bit ALU. Accepted operations land in a
// stage-1 register, the ALU evaluates them combinationally, and result + flags
// + tag are written into an output FIFO of DEPTH-1 entries.
//   clk, reset : clock, async active-high reset (discards everything in flight)
//   io         : in_* operation channel, out_* result channel (slave side)
//   clr_sticky : synchronous clear of sticky_ovf (a same-cycle set wins)
//   sticky_ovf : latched when any overflowing result is written to the FIFO
//   op_count   : output handshakes, wrapping
//   busy       : stage 1 or FIFO holds an operation
// -----------------------------------------------------------------------------
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_stage_if.slave io,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);
    localparam int ENTRIES = DEPTH - 1;
    localparam int CW      = $clog2(DEPTH);
    localparam int W       = $bits(alu_out_t) + TAG_W;

    logic             s1_valid;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic [2:0]       s1_cmd;
    logic [TAG_W-1:0] s1_tag;

    alu_out_t         alu_y;
    alu_out_t         head_y;
    logic [W-1:0]     fifo_rdata;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [3:0]       occ;
    logic             accept;
    logic             push;
    logic             pop;

    // occupancy comes from registers only, so in_ready never sees out_ready
    assign occ         = 4'(fifo_count) + 4'(s1_valid);
    assign io.in_ready = (occ < 4'(DEPTH));
    assign accept      = io.in_valid & io.in_ready;
    assign pop         = io.out_valid & io.out_ready;
    // stage 1 waits only in the one state where the FIFO is full and not draining
    assign push        = s1_valid & (~fifo_full | pop);
    assign busy        = (occ != 4'd0);

    alu u_alu (
        .a   (s1_a),
        .b   (s1_b),
        .cmd (s1_cmd),
        .y   (alu_y)
    );

    alu_out_fifo #(
        .ENTRIES (ENTRIES),
        .W       (W),
        .CW      (CW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({alu_y, s1_tag}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_y, io.out_tag} = fifo_rdata;
    assign io.out_valid         = ~fifo_empty;
    assign io.out_result        = head_y.result;
    assign io.out_carryout      = head_y.carryout;
    assign io.out_zero          = head_y.zero;
    assign io.out_overflow      = head_y.overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_cmd     <= '0;
            s1_tag     <= '0;
            sticky_ovf <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= io.in_a;
                s1_b     <= io.in_b;
                s1_cmd   <= io.in_cmd;
                s1_tag   <= io.in_tag;
            end else if (push) begin
                s1_valid <= 1'b0;
            end

            if (push && alu_y.overflow) sticky_ovf <= 1'b1;
            else if (clr_sticky)        sticky_ovf <= 1'b0;

            if (pop) op_count <= op_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed test of alu_issue_stage (DEPTH=3, TAG_W=4, CNT_W=16): reset state,
// ADD/SUB/SLT/logic results and flags, sticky overflow, back-pressure, full
// throughput and mid-flight reset. Inputs change and outputs are checked 1 ns
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        clr_sticky;
    logic        sticky_ovf;
    logic [15:0] op_count;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_stage_if #(.TAG_W(4)) io ();

    alu_issue_stage #(.DEPTH(3), .TAG_W(4), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .io         (io),
        .clr_sticky (clr_sticky),
        .sticky_ovf (sticky_ovf),
        .op_count   (op_count),
        .busy       (busy)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [2:0] cmd, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] tag);
        io.in_valid = 1'b1;
        io.in_cmd   = cmd;
        io.in_a     = a;
        io.in_b     = b;
        io.in_tag   = tag;
    endtask

    // one accepted operation: ready must be high, accept happens on this edge
    task automatic issue(input string nm, input logic [2:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
        drive_op(cmd, a, b, tag);
        check({nm, ".in_ready"}, io.in_ready, 1);
        tick();
        io.in_valid = 1'b0;
    endtask

    task automatic expect_head(input string nm, input logic [31:0] r, input logic c,
                               input logic z, input logic o, input logic [3:0] t);
        check({nm, ".out_valid"}, io.out_valid, 1);
        check({nm, ".result"}, io.out_result, r);
        check({nm, ".carry"}, io.out_carryout, c);
        check({nm, ".zero"}, io.out_zero, z);
        check({nm, ".ovf"}, io.out_overflow, o);
        check({nm, ".tag"}, io.out_tag, t);
    endtask

    // back-pressure vectors, hand-computed results
    logic [2:0]  st_cmd [5];
    logic [31:0] st_a   [5];
    logic [31:0] st_b   [5];
    logic [31:0] st_r   [5];
    logic        st_c   [5];

    int acc;
    logic rdy;

    initial begin
        st_cmd[0] = CMD_ADD; st_a[0] = 32'h10;       st_b[0] = 32'h20;       st_r[0] = 32'h30;       st_c[0] = 1'b0;
        st_cmd[1] = CMD_SUB; st_a[1] = 32'h100;      st_b[1] = 32'h1;        st_r[1] = 32'hFF;       st_c[1] = 1'b1;
        st_cmd[2] = CMD_AND; st_a[2] = 32'hF0F0F0F0; st_b[2] = 32'h0FF00FF0; st_r[2] = 32'h00F000F0; st_c[2] = 1'b0;
        st_cmd[3] = CMD_OR;  st_a[3] = 32'h1;        st_b[3] = 32'h2;        st_r[3] = 32'h3;        st_c[3] = 1'b0;
        st_cmd[4] = CMD_XOR; st_a[4] = 32'hFF;       st_b[4] = 32'h0F;       st_r[4] = 32'hF0;       st_c[4] = 1'b0;

        // reset
        reset = 1'b1; clr_sticky = 1'b0;
        io.in_valid = 1'b0; io.in_a = '0; io.in_b = '0; io.in_cmd = '0; io.in_tag = '0;
        io.out_ready = 1'b0;
        tick(); tick();
        check("rst.in_ready", io.in_ready, 1);
        check("rst.out_valid", io.out_valid, 0);
        check("rst.result", io.out_result, 0);
        check("rst.flags", {io.out_carryout, io.out_zero, io.out_overflow}, 0);
        check("rst.tag", io.out_tag, 0);
        check("rst.sticky", sticky_ovf, 0);
        check("rst.op_count", op_count, 0);
        check("rst.busy", busy, 0);
        reset = 1'b0;
        tick();

        // ADD with carry-out and zero, 2-cycle latency
        io.out_ready = 1'b1;
        issue("add1", CMD_ADD, 32'hFFFFFFFF, 32'h1, 4'd1);
        check("add1.lat1_valid", io.out_valid, 0);
        check("add1.busy", busy, 1);
        tick();
        expect_head("add1", 32'h0, 1'b1, 1'b1, 1'b0, 4'd1);
        check("add1.cnt_before", op_count, 0);
        tick();
        check("add1.op_count", op_count, 1);
        check("add1.drained", io.out_valid, 0);

        // SUB and SLT
        issue("sub", CMD_SUB, 32'd5, 32'd7, 4'd2);
        tick();
        expect_head("sub", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 4'd2);
        tick();
        issue("slt", CMD_SLT, 32'hFFFFFFFF, 32'h1, 4'd3);
        tick();
        expect_head("slt", 32'h1, 1'b0, 1'b0, 1'b0, 4'd3);
        tick();
        check("slt.op_count", op_count, 3);

        // sticky overflow: set, set-beats-clear, clear
        issue("ovf1", CMD_ADD, 32'h7FFFFFFF, 32'h1, 4'd4);
        tick();
        expect_head("ovf1", 32'h80000000, 1'b0, 1'b0, 1'b1, 4'd4);
        check("ovf1.sticky", sticky_ovf, 1);
        tick();
        issue("ovf2", CMD_ADD, 32'h7FFFFFFF, 32'h1, 4'd5);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("ovf2.set_wins", sticky_ovf, 1);
        expect_head("ovf2", 32'h80000000, 1'b0, 1'b0, 1'b1, 4'd5);
        tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("clr.sticky", sticky_ovf, 0);
        check("clr.op_count", op_count, 5);

        // back-pressure: 5 ops offered, only DEPTH=3 accepted
        io.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (acc < 5) drive_op(st_cmd[acc], st_a[acc], st_b[acc], 4'(6 + acc));
            rdy = io.in_ready;
            tick();
            if (rdy) acc++;
            if (i >= 3) begin
                expect_head("stall.hold", st_r[0], st_c[0], 1'b0, 1'b0, 4'd6);
            end
        end
        check("stall.accepted", acc, 3);
        check("stall.in_ready", io.in_ready, 0);
        check("stall.busy", busy, 1);
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_head("stall.drain", st_r[k], st_c[k], 1'b0, 1'b0, 4'(6 + k));
            tick();
        end
        check("stall.empty", io.out_valid, 0);
        check("stall.idle", busy, 0);
        check("stall.op_count", op_count, 8);

        // full throughput: one accept and one output per cycle
        for (int k = 0; k < 22; k++) begin
            if (k < 20) begin
                drive_op(CMD_ADD, 32'(k), 32'd100, 4'(k));
                check("tp.in_ready", io.in_ready, 1);
            end else begin
                io.in_valid = 1'b0;
            end
            if (k >= 2) expect_head("tp.head", 32'(k - 2 + 100), 1'b0, 1'b0, 1'b0, 4'(k - 2));
            else        check("tp.fill", io.out_valid, 0);
            tick();
        end
        check("tp.empty", io.out_valid, 0);
        check("tp.op_count", op_count, 28);

        // reset with three operations in flight
        io.out_ready = 1'b0;
        issue("fl0", CMD_ADD, 32'd1, 32'd1, 4'd11);
        issue("fl1", CMD_ADD, 32'd2, 32'd2, 4'd12);
        issue("fl2", CMD_ADD, 32'd3, 32'd3, 4'd13);
        check("fl.pre_valid", io.out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("mrst.out_valid", io.out_valid, 0);
        check("mrst.busy", busy, 0);
        check("mrst.op_count", op_count, 0);
        check("mrst.in_ready", io.in_ready, 1);
        check("mrst.result", io.out_result, 0);
        tick();
        reset = 1'b0;
        io.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("mrst.no_stale", io.out_valid, 0);
            tick();
        end
        check("mrst.pop_empty", op_count, 0);
        issue("post", CMD_ADD, 32'd3, 32'd4, 4'hA);
        tick();
        expect_head("post", 32'd7, 1'b0, 1'b0, 1'b0, 4'hA);
        tick();
        check("post.op_count", op_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
